tick_period_meter: RTL and testbench
====================================

TICK_PERIOD_METER -- requirements
Module: tick_period_meter

Interface
REQ-001 SHALL have parameter EXPECTED_CYCLE, default 10_000_000, nominal clk cycles between input ticks.
REQ-002 SHALL have parameter TOLERANCE, default 1000, max allowed |period - EXPECTED_CYCLE| for an in-tolerance period.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, consecutive in-tolerance periods required for lock.
REQ-004 SHALL have parameter TIMEOUT_CYCLE, default 2*EXPECTED_CYCLE, cycles without tick before timeout; W = $clog2(TIMEOUT_CYCLE+1).
REQ-005 SHALL have port clk  input  1  system clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port enable  input  1  when low, freeze all state; ticks ignored.
REQ-008 SHALL have port clear  input  1  synchronous clear to reset state.
REQ-009 SHALL have port i_tick  input  1  single-cycle tick pulse from a tick generator.
REQ-010 SHALL have port o_period  output  W  last measured period in clk cycles.
REQ-011 SHALL have port o_valid  output  1  one-cycle pulse when o_period updates.
REQ-012 SHALL have port o_locked  output  1  LOCK_COUNT consecutive in-tolerance periods seen.
REQ-013 SHALL have port o_timeout  output  1  no tick for TIMEOUT_CYCLE cycles.
REQ-014 SHALL have ports o_min_period and o_max_period  output  W  measured extremes (see Configuration).

Function
REQ-015 SHALL implement states IDLE (no reference tick yet), MEASURE, TIMEOUT.
REQ-016 IDLE: on enable & i_tick -> MEASURE, counter <= 1; no o_valid.
REQ-017 MEASURE, enable high, no tick: counter += 1.
REQ-018 MEASURE, enable & i_tick: o_period <= counter, o_valid = 1 on next cycle (1-cycle latency), counter <= 1; period = clk-cycle distance between ticks, excluding enable-low cycles.
REQ-019 Lock evaluation in the same update: in-tolerance -> match count += 1, saturating at LOCK_COUNT; o_locked <= 1 when match count reaches LOCK_COUNT; out-of-tolerance -> match count <= 0, o_locked <= 0.
REQ-020 MEASURE, enable high, counter == TIMEOUT_CYCLE, no tick: -> TIMEOUT, o_timeout <= 1, o_locked <= 0, match count <= 0; counter holds.
REQ-021 i_tick has priority over timeout in the same cycle: period TIMEOUT_CYCLE is measured normally; no timeout.
REQ-022 TIMEOUT: on enable & i_tick -> MEASURE, counter <= 1, o_timeout <= 0; no o_valid for that tick.
REQ-023 enable low: state, counter, outputs hold; o_valid = 0; i_tick ignored.
REQ-024 clear (priority over enable and i_tick): identical effect to reset, synchronous.
REQ-025 o_valid SHALL never be high for two consecutive cycles unless ticks arrive on consecutive enabled cycles (period 1).

Reset
REQ-026 On rst: state IDLE, counter 0, match count 0, o_period 0, o_valid 0, o_locked 0, o_timeout 0, o_min_period all-ones, o_max_period 0.
REQ-027 rst mid-measurement SHALL discard the partial period; the first post-reset tick only re-arms (REQ-016).

Configuration
REQ-028 Macro TICK_PERIOD_METER_STATS_EN defined: on each o_valid update, o_min_period <= min(o_min_period, period), o_max_period <= max(o_max_period, period); clear restores reset values.
REQ-029 Macro undefined: no min/max registers; o_min_period and o_max_period driven constant 0; all other behaviour identical.

Verification (EXPECTED_CYCLE=10, TOLERANCE=1, LOCK_COUNT=3, TIMEOUT_CYCLE=20)
REQ-030 Ticks every 10 cycles, 4 ticks -> 3 o_valid pulses, o_period=10 each, o_locked rises with 3rd pulse.
REQ-031 Locked, then periods 10,13 -> 13 reported, o_locked falls in the same cycle as that o_valid; 3 further 10-cycle periods re-lock.
REQ-032 Tick then silence -> o_timeout=1 twenty cycles after the tick, o_locked=0; next tick clears o_timeout without o_valid; tick 10 cycles later -> o_period=10.
REQ-033 Second tick exactly 20 cycles after the first -> o_valid, o_period=20, o_timeout stays 0.
REQ-034 Tick at cycle 0, enable low cycles 3-7, tick at cycle 15 -> o_period=10.
REQ-035 STATS_EN: periods 9,12,10 -> min=9, max=12; clear -> min all-ones, max 0, state IDLE; rst mid-period -> next tick gives no o_valid.

Source files
------------

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures the clk-cycle distance between successive
// i_tick pulses, reports each period with a one-cycle o_valid pulse, tracks
// lock (LOCK_COUNT consecutive in-tolerance periods) and flags a timeout
// when no tick arrives for TIMEOUT_CYCLE enabled cycles.
// Optional feature: define TICK_PERIOD_METER_STATS_EN to track the minimum
// and maximum reported period; otherwise o_min_period/o_max_period are 0.
// Handshake: o_valid is a single-cycle qualifier for o_period (no ready);
// o_period, o_locked and the extremes are all updated on that same cycle
// and hold their value until the next update.
// The FSM state is visible for checkers as the signal state_q.
module tick_period_meter #(
  parameter int EXPECTED_CYCLE = 10_000_000,
  parameter int TOLERANCE      = 1000,
  parameter int LOCK_COUNT     = 4,
  parameter int TIMEOUT_CYCLE  = 2 * EXPECTED_CYCLE,
  localparam int W             = $clog2(TIMEOUT_CYCLE + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clear,
  input  logic         i_tick,
  output logic [W-1:0] o_period,
  output logic         o_valid,
  output logic         o_locked,
  output logic         o_timeout,
  output logic [W-1:0] o_min_period,
  output logic [W-1:0] o_max_period
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] MATCH_MAX   = MW'(LOCK_COUNT);
  localparam logic [W-1:0]  TIMEOUT_CNT = W'(TIMEOUT_CYCLE);
  localparam logic [31:0]   TOL_LO = (EXPECTED_CYCLE > TOLERANCE) ?
                                     32'(EXPECTED_CYCLE - TOLERANCE) : 32'd0;
  localparam logic [31:0]   TOL_HI = 32'(EXPECTED_CYCLE + TOLERANCE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [MW-1:0] match_q, match_d;
  logic [W-1:0]  period_d;
  logic          valid_d, locked_d, timeout_d;
  logic          period_update;
  logic          in_tol;
  logic [31:0]   count_wide;

  // Distance of the running count from the expected period.
  always_comb begin
    count_wide = 32'(count_q);
    in_tol     = (count_wide >= TOL_LO) && (count_wide <= TOL_HI);
  end

  // Next-state and next-output logic; clear acts like a synchronous reset.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    match_d       = match_q;
    period_d      = o_period;
    valid_d       = 1'b0;
    locked_d      = o_locked;
    timeout_d     = o_timeout;
    period_update = 1'b0;
    if (clear) begin
      state_d   = ST_IDLE;
      count_d   = '0;
      match_d   = '0;
      period_d  = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (i_tick) begin
            state_d = ST_MEASURE;
            count_d = W'(1);
          end
        end
        ST_MEASURE: begin
          if (i_tick) begin
            period_update = 1'b1;
            period_d      = count_q;
            valid_d       = 1'b1;
            count_d       = W'(1);
            if (in_tol) begin
              match_d = (match_q == MATCH_MAX) ? MATCH_MAX : match_q + MW'(1);
              if (match_d == MATCH_MAX) locked_d = 1'b1;
            end else begin
              match_d  = '0;
              locked_d = 1'b0;
            end
          end else if (count_q == TIMEOUT_CNT) begin
            state_d   = ST_TIMEOUT;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
          end else begin
            count_d = count_q + W'(1);
          end
        end
        ST_TIMEOUT: begin
          if (i_tick) begin
            state_d   = ST_MEASURE;
            count_d   = W'(1);
            timeout_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
          match_d = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      match_q   <= '0;
      o_period  <= '0;
      o_valid   <= 1'b0;
      o_locked  <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      match_q   <= match_d;
      o_period  <= period_d;
      o_valid   <= valid_d;
      o_locked  <= locked_d;
      o_timeout <= timeout_d;
    end
  end

`ifdef TICK_PERIOD_METER_STATS_EN
  logic [W-1:0] min_q, max_q;

  // Track the extremes of every reported period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else if (clear) begin
      min_q <= '1;
      max_q <= '0;
    end else if (period_update) begin
      if (count_q < min_q) min_q <= count_q;
      if (count_q > max_q) max_q <= count_q;
    end
  end

  assign o_min_period = min_q;
  assign o_max_period = max_q;
`else
  assign o_min_period = '0;
  assign o_max_period = '0;
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter (EXPECTED_CYCLE=10, TOLERANCE=1, LOCK_COUNT=3,
// TIMEOUT_CYCLE=20). A reference model counts enabled cycles between ticks,
// pushes each expected report into exp_q, and a monitor on the falling edge
// pops and compares whenever the design presents o_valid.
module tb_tick_period_meter;

  localparam int EXP  = 10;
  localparam int TOL  = 1;
  localparam int LOCK = 3;
  localparam int TO   = 20;
  localparam int W    = $clog2(TO + 1);
`ifdef TICK_PERIOD_METER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         clear = 1'b0;
  logic         i_tick = 1'b0;
  logic [W-1:0] o_period, o_min_period, o_max_period;
  logic         o_valid, o_locked, o_timeout;

  tick_period_meter #(
    .EXPECTED_CYCLE(EXP),
    .TOLERANCE(TOL),
    .LOCK_COUNT(LOCK),
    .TIMEOUT_CYCLE(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .clear(clear),
    .i_tick(i_tick),
    .o_period(o_period),
    .o_valid(o_valid),
    .o_locked(o_locked),
    .o_timeout(o_timeout),
    .o_min_period(o_min_period),
    .o_max_period(o_max_period)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: periods are distances in enabled-cycle index between ticks.
  int  m_idx, m_last, m_period, m_min, m_max, m_run;
  bit  m_armed, m_tmo, m_locked;
  bit  done = 1'b0;
  logic [3*W:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic model_reset();
    m_idx    = 0;
    m_last   = 0;
    m_period = 0;
    m_min    = (1 << W) - 1;
    m_max    = 0;
    m_run    = 0;
    m_armed  = 1'b0;
    m_tmo    = 1'b0;
    m_locked = 1'b0;
  endtask

  function automatic int exp_min();
    return STATS ? m_min : 0;
  endfunction

  function automatic int exp_max();
    return STATS ? m_max : 0;
  endfunction

  task automatic model_step(bit en, bit tk, bit clr);
    int p;
    int dev;
    if (clr) begin
      model_reset();
    end else if (en) begin
      m_idx++;
      if (tk && m_armed && !m_tmo) begin
        p        = m_idx - m_last;
        m_last   = m_idx;
        m_period = p;
        dev      = (p > EXP) ? p - EXP : EXP - p;
        m_run    = (dev <= TOL) ? m_run + 1 : 0;
        m_locked = (m_run >= LOCK);
        if (p < m_min) m_min = p;
        if (p > m_max) m_max = p;
        exp_q.push_back({m_locked, W'(p), W'(exp_min()), W'(exp_max())});
      end else if (tk) begin
        m_armed = 1'b1;
        m_tmo   = 1'b0;
        m_last  = m_idx;
      end else if (m_armed && !m_tmo && (m_idx - m_last == TO)) begin
        m_tmo    = 1'b1;
        m_locked = 1'b0;
        m_run    = 0;
      end
    end
  endtask

  // Driver tasks.
  task automatic step(bit en, bit tk, bit clr);
    enable = en;
    i_tick = tk;
    clear  = clr;
    @(posedge clk);
    model_step(en, tk, clr);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    i_tick = 1'b0;
    clear  = 1'b0;
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // n-1 quiet cycles then a tick; dis_pct is the chance of an enable-low quiet cycle.
  task automatic run_gap(int n, int dis_pct);
    for (int i = 1; i < n; i++) step($urandom_range(0, 99) >= dis_pct, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  // Scoreboard comparison helper, used only by the monitor.
  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on o_valid, check held outputs every cycle.
  always @(negedge clk) begin
    logic [3*W:0] e;
    chk("valid", o_valid, exp_q.size() > 0);
    if (o_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("report_period", o_period, e[3*W-1:2*W]);
      chk("report_locked", o_locked, e[3*W]);
      chk("report_min", o_min_period, e[2*W-1:W]);
      chk("report_max", o_max_period, e[W-1:0]);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end
    chk("timeout", o_timeout, m_tmo);
    chk("locked", o_locked, m_locked);
    chk("period_hold", o_period, m_period);
    chk("min_hold", o_min_period, exp_min());
    chk("max_hold", o_max_period, exp_max());
    if (done) begin
      chk("leftover_expected", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int r;
    model_reset();
    do_reset();
    // steady 10-cycle ticks: three reports, lock on the third
    step(1'b1, 1'b1, 1'b0);
    repeat (3) run_gap(10, 0);
    // one bad period drops lock, three good ones restore it
    run_gap(10, 0);
    run_gap(13, 0);
    repeat (3) run_gap(10, 0);
    // silence into timeout, re-arm, then a normal period
    repeat (25) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    run_gap(10, 0);
    // tick exactly at the timeout count is measured, no timeout
    run_gap(20, 0);
    // enable low for five cycles inside a period is not counted
    for (int c = 1; c < 15; c++) step(!(c >= 3 && c <= 7), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    // clear, then periods 9, 12, 10 for the extremes
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    run_gap(9, 0);
    run_gap(12, 0);
    run_gap(10, 0);
    step(1'b1, 1'b0, 1'b1);
    run_gap(5, 0);
    run_gap(10, 0);
    // reset in the middle of a period: next tick only re-arms
    repeat (4) step(1'b1, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    run_gap(10, 0);
    // back-to-back ticks give consecutive reports
    repeat (3) run_gap(1, 0);
    // randomized traffic
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      run_gap($urandom_range(EXP - 1, EXP + 1), 10);
      else if (r < 85) run_gap($urandom_range(1, TO + 4), 15);
      else if (r < 91) step($urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
      else if (r < 96) run_gap(1, 0);
      else if (r < 98) step(1'b0, 1'b1, 1'b0);
      else             do_reset();
    end
    repeat (3) step(1'b1, 1'b0, 1'b0);
    done = 1'b1;
  end

endmodule
